// File: rtl/route_lookup_sched.sv
// route_lookup_sched: shared routing-table controller.
// After reset it preloads the DESTS-entry table from an external ROM (one entry
// per cycle), raises ready, then serves destination-to-port lookups from PORTS
// requesters through a single read port, one round-robin grant per cycle.
// Optional feature macro: ROUTE_TABLE_WRITE_EN adds wr_en/wr_addr/wr_data for
// runtime table updates; a write cycle grants no lookup.
//
// Lookup handshake: lk_req[i] is a level held with a stable lk_dest slice until
// lk_ack[i] is seen; lk_ack is a registered one-hot single-cycle pulse with
// lk_port valid in the same cycle. A port whose ack is high this cycle is not
// eligible, so a request still held through its ack cycle is never acked twice.
module route_lookup_sched #(
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 8,
    parameter int SIZE      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [SIZE-2:0]               table_addr,
    input  logic [PORT_BITS-1:0]          table_data,
    output logic                          ready,
    input  logic [PORTS-1:0]              lk_req,
    input  logic [PORTS*(SIZE-1)-1:0]     lk_dest,
    output logic [PORTS-1:0]              lk_ack,
    output logic [PORT_BITS-1:0]          lk_port
`ifdef ROUTE_TABLE_WRITE_EN
    ,
    input  logic                          wr_en,
    input  logic [SIZE-2:0]               wr_addr,
    input  logic [PORT_BITS-1:0]          wr_data
`endif
);

    localparam int DEST_BITS = SIZE - 1;
    localparam int DESTS     = 2 ** DEST_BITS;
    localparam int RR_W      = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {
        LOAD  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PORT_BITS-1:0]   route_table [DESTS];
    logic [RR_W-1:0]        rr;
    logic [RR_W-1:0]        rr_next;
    logic [RR_W-1:0]        grant_idx;
    logic                   grant_valid;
    logic [PORTS-1:0]       grant_onehot;
    logic [PORTS-1:0]       eligible;
    logic [DEST_BITS-1:0]   grant_dest;
    logic                   last_load;
    logic                   wr_active;
    int                     scan_idx;

    assign last_load = (table_addr == DEST_BITS'(DESTS - 1));

`ifdef ROUTE_TABLE_WRITE_EN
    assign wr_active = (state == SERVE) && wr_en;
`else
    assign wr_active = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    // Next state: leave LOAD on the write of the final table entry.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (last_load) state_next = SERVE;
            SERVE:   state_next = SERVE;
            default: state_next = LOAD;
        endcase
    end

    // Round-robin arbiter: first eligible port at or above rr, wrapping mod PORTS.
    always_comb begin
        eligible     = lk_req & ~lk_ack;
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_dest   = '0;
        grant_onehot = '0;
        scan_idx     = 0;
        for (int k = 0; k < PORTS; k++) begin
            scan_idx = int'(rr) + k;
            if (scan_idx >= PORTS) scan_idx = scan_idx - PORTS;
            for (int j = 0; j < PORTS; j++) begin
                if (!grant_valid && (j == scan_idx) && eligible[j]) begin
                    grant_valid     = 1'b1;
                    grant_idx       = RR_W'(j);
                    grant_dest      = lk_dest[j*DEST_BITS +: DEST_BITS];
                    grant_onehot[j] = 1'b1;
                end
            end
        end
        if (grant_idx == RR_W'(PORTS - 1)) rr_next = '0;
        else                               rr_next = grant_idx + 1'b1;
    end

    // Preload sequencing and registered lookup responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            table_addr <= '0;
            ready      <= 1'b0;
            lk_ack     <= '0;
            lk_port    <= '0;
            rr         <= '0;
        end else begin
            case (state)
                LOAD: begin
                    lk_ack <= '0;
                    if (last_load) begin
                        table_addr <= '0;
                        ready      <= 1'b1;
                    end else begin
                        table_addr <= table_addr + 1'b1;
                    end
                end
                SERVE: begin
                    if (wr_active || !grant_valid) begin
                        lk_ack <= '0;
                    end else begin
                        lk_ack  <= grant_onehot;
                        lk_port <= route_table[grant_dest];
                        rr      <= rr_next;
                    end
                end
                default: lk_ack <= '0;
            endcase
        end
    end

    // Table storage: ROM preload in LOAD, optional runtime writes in SERVE; never cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == LOAD) begin
                route_table[table_addr] <= table_data;
            end
`ifdef ROUTE_TABLE_WRITE_EN
            else if (wr_active) begin
                route_table[wr_addr] <= wr_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_route_lookup_sched.sv
// Testbench for route_lookup_sched (SIZE=8, PORTS=5, PORT_BITS=8).
// ROM model returns addr ^ 7'h05. Build with ROUTE_TABLE_WRITE_EN defined to
// also exercise the runtime write path.
module tb_route_lookup_sched;

    localparam int PORTS     = 5;
    localparam int PORT_BITS = 8;
    localparam int SIZE      = 8;
    localparam int DB        = SIZE - 1;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [DB-1:0]            table_addr;
    logic [PORT_BITS-1:0]     table_data;
    logic                     ready;
    logic [PORTS-1:0]         lk_req = '0;
    logic [PORTS*DB-1:0]      lk_dest = '0;
    logic [PORTS-1:0]         lk_ack;
    logic [PORT_BITS-1:0]     lk_port;
`ifdef ROUTE_TABLE_WRITE_EN
    logic                     wr_en = 1'b0;
    logic [DB-1:0]            wr_addr = '0;
    logic [PORT_BITS-1:0]     wr_data = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] exp_q[$];

    typedef struct {
        logic [PORTS-1:0]     req;
        logic [PORTS*DB-1:0]  dests;
        logic [PORTS-1:0]     exp_ack;
        logic [PORT_BITS-1:0] exp_port;
    } vec_t;
    vec_t vecs[17];

    route_lookup_sched #(.PORTS(PORTS), .PORT_BITS(PORT_BITS), .SIZE(SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .table_addr (table_addr),
        .table_data (table_data),
        .ready      (ready),
        .lk_req     (lk_req),
        .lk_dest    (lk_dest),
        .lk_ack     (lk_ack),
        .lk_port    (lk_port)
`ifdef ROUTE_TABLE_WRITE_EN
        ,
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
`endif
    );

    // Clock and ROM model
    always #5 clk = ~clk;
    assign table_data = {1'b0, table_addr ^ 7'h05};

    function automatic logic [PORTS*DB-1:0] mkd(input logic [DB-1:0] d0, d1, d2, d3, d4);
        return {d4, d3, d2, d1, d0};
    endfunction

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold reset for two edges, verify reset values, release
    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ack", 32'(lk_ack), 32'd0);
        check("rst_port", 32'(lk_port), 32'd0);
        check("rst_addr", 32'(table_addr), 32'd0);
        reset = 1'b0;
    endtask

    // 128 preload edges: no acks, ready only after the last one
    task automatic run_preload();
        for (int e = 1; e <= 128; e++) begin
            tick();
            check($sformatf("load_ack_e%0d", e), 32'(lk_ack), 32'd0);
            if (e == 40)  check("load_addr40", 32'(table_addr), 32'd40);
            if (e == 127) check("load_ready127", 32'(ready), 32'd0);
            if (e == 128) check("load_ready128", 32'(ready), 32'd1);
            if (e == 128) check("load_addr_wrap", 32'(table_addr), 32'd0);
        end
    endtask

    initial begin
        logic [12:0] e;

        vecs[0]  = '{5'b11111, mkd(7'd10, 7'd11, 7'd12, 7'd13, 7'd14), 5'b00001, 8'd15};
        vecs[1]  = '{5'b11110, mkd(7'd10, 7'd11, 7'd12, 7'd13, 7'd14), 5'b00010, 8'd14};
        vecs[2]  = '{5'b11100, mkd(7'd10, 7'd11, 7'd12, 7'd13, 7'd14), 5'b00100, 8'd9};
        vecs[3]  = '{5'b11000, mkd(7'd10, 7'd11, 7'd12, 7'd13, 7'd14), 5'b01000, 8'd8};
        vecs[4]  = '{5'b10000, mkd(7'd10, 7'd11, 7'd12, 7'd13, 7'd14), 5'b10000, 8'd11};
        vecs[5]  = '{5'b00000, mkd(7'd10, 7'd11, 7'd12, 7'd13, 7'd14), 5'b00000, 8'd11};
        vecs[6]  = '{5'b11111, mkd(7'd10, 7'd11, 7'd12, 7'd13, 7'd14), 5'b00001, 8'd15};
        vecs[7]  = '{5'b00101, mkd(7'd20, 7'd11, 7'd30, 7'd13, 7'd14), 5'b00100, 8'd27};
        vecs[8]  = '{5'b00101, mkd(7'd20, 7'd11, 7'd30, 7'd13, 7'd14), 5'b00001, 8'd17};
        vecs[9]  = '{5'b00101, mkd(7'd20, 7'd11, 7'd30, 7'd13, 7'd14), 5'b00100, 8'd27};
        vecs[10] = '{5'b00101, mkd(7'd20, 7'd11, 7'd30, 7'd13, 7'd14), 5'b00001, 8'd17};
        vecs[11] = '{5'b00000, mkd(7'd20, 7'd11, 7'd30, 7'd13, 7'd14), 5'b00000, 8'd17};
        vecs[12] = '{5'b01000, mkd(7'd20, 7'd11, 7'd30, 7'd127, 7'd64), 5'b01000, 8'h7A};
        vecs[13] = '{5'b01000, mkd(7'd20, 7'd11, 7'd30, 7'd127, 7'd64), 5'b00000, 8'h7A};
        vecs[14] = '{5'b01000, mkd(7'd20, 7'd11, 7'd30, 7'd127, 7'd64), 5'b01000, 8'h7A};
        vecs[15] = '{5'b11000, mkd(7'd20, 7'd11, 7'd30, 7'd127, 7'd64), 5'b10000, 8'h45};
        vecs[16] = '{5'b00000, mkd(7'd20, 7'd11, 7'd30, 7'd127, 7'd64), 5'b00000, 8'h45};

        // Preload with port 1 requesting dest 3 from reset release
        lk_req  = 5'b00010;
        lk_dest = mkd(7'd0, 7'd3, 7'd0, 7'd0, 7'd0);
        apply_reset();
        run_preload();
        tick();
        check("pre_ack", 32'(lk_ack), 32'b00010);
        check("pre_port", 32'(lk_port), 32'h06);
        lk_req = '0;
        tick();
        check("pre_ack_drop", 32'(lk_ack), 32'd0);

        // Fresh table and rr=0, then the vector table
        apply_reset();
        run_preload();
        for (int i = 0; i < 17; i++) begin
            lk_req  = vecs[i].req;
            lk_dest = vecs[i].dests;
            exp_q.push_back({vecs[i].exp_ack, vecs[i].exp_port});
            tick();
            e = exp_q.pop_front();
            check($sformatf("vec%0d_ack", i), 32'(lk_ack), 32'(e[12:8]));
            check($sformatf("vec%0d_port", i), 32'(lk_port), 32'(e[7:0]));
        end

`ifdef ROUTE_TABLE_WRITE_EN
        // Runtime write collides with a lookup of the same entry
        lk_req  = 5'b00010;
        lk_dest = mkd(7'd0, 7'd3, 7'd0, 7'd0, 7'd0);
        wr_en   = 1'b1;
        wr_addr = 7'd3;
        wr_data = 8'd2;
        tick();
        check("wr_cycle_ack", 32'(lk_ack), 32'd0);
        wr_en = 1'b0;
        tick();
        check("wr_after_ack", 32'(lk_ack), 32'b00010);
        check("wr_after_port", 32'(lk_port), 32'd2);
        lk_req = '0;
        tick();
        check("wr_drop_ack", 32'(lk_ack), 32'd0);
`endif

        // Reset while lk_ack[3] is high
        lk_req  = 5'b01000;
        lk_dest = mkd(7'd0, 7'd0, 7'd0, 7'd5, 7'd0);
        tick();
        check("srv_ack3", 32'(lk_ack), 32'b01000);
        check("srv_port3", 32'(lk_port), 32'd0);
        reset = 1'b1;
        tick();
        check("srv_rst_ack", 32'(lk_ack), 32'd0);
        check("srv_rst_ready", 32'(ready), 32'd0);
        check("srv_rst_addr", 32'(table_addr), 32'd0);
        reset = 1'b0;
        run_preload();
        tick();
        check("srv_reload_ack", 32'(lk_ack), 32'b01000);
        check("srv_reload_port", 32'(lk_port), 32'd0);
        lk_req = '0;
        tick();

        // Reset in the middle of a preload
        apply_reset();
        for (int k = 0; k < 40; k++) tick();
        check("mid_addr40", 32'(table_addr), 32'd40);
        reset = 1'b1;
        tick();
        check("mid_rst_addr", 32'(table_addr), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        run_preload();
        lk_req  = 5'b10000;
        lk_dest = mkd(7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        tick();
        check("mid_final_ack", 32'(lk_ack), 32'b10000);
        check("mid_final_port", 32'(lk_port), 32'd5);
        lk_req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
